spi_slave: RTL and testbench

// SPI mode-0 responder: the target-side counterpart of the team's spi_master. Oversamples

---
 rtl/spi_slave.sv | 171 +++++++++++++++++
 tb/tb_spi_slave.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI mode-0 responder: oversamples cs_n/sclk/mosi on clk, deserialises words from mosi
// and shifts words from a one-entry valid/ready tx buffer out on miso, MSB first.
module spi_slave #(
  parameter int                WIDTH       = 8,
  parameter logic [WIDTH-1:0]  IDLE_WORD   = '0,
  parameter int                SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_cs_n,
  input  logic             i_sclk,
  input  logic             i_mosi,
  output logic             o_miso,
  output logic             o_miso_oe,
  input  logic [WIDTH-1:0] i_tx_data,
  input  logic             i_tx_valid,
  output logic             o_tx_ready,
  output logic [WIDTH-1:0] o_rx_data,
  output logic             o_rx_valid,
  output logic             o_underrun,
  output logic             o_state
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t                 r_state, w_state_next;
  logic [SYNC_STAGES-1:0] r_cs_sync, r_sclk_sync, r_mosi_sync;
  logic                   r_cs_d, r_sclk_d;
  logic [CW-1:0]          r_cnt;
  logic [WIDTH-1:0]       r_rx_shift, r_tx_shift, r_buf, r_rx_data;
  logic                   r_buf_full, r_reload, r_und_pend;
  logic                   r_miso, r_miso_oe, r_rx_valid, r_underrun;

  logic                   w_cs, w_sclk, w_mosi;
  logic                   w_cs_fall, w_cs_rise, w_sclk_rise, w_sclk_fall;
  logic                   w_load, w_wr;
  logic [WIDTH-1:0]       w_next_word, w_rx_next;
  logic [CW-1:0]          w_bit_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cs_sync   <= '1;
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_cs_d      <= 1'b1;
      r_sclk_d    <= 1'b0;
    end else begin
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs_n};
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
      r_cs_d      <= w_cs;
      r_sclk_d    <= w_sclk;
    end
  end

  assign w_cs        = r_cs_sync[SYNC_STAGES-1];
  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs_fall   = r_cs_d & ~w_cs;
  assign w_cs_rise   = ~r_cs_d & w_cs;
  assign w_sclk_rise = ~r_sclk_d & w_sclk;
  assign w_sclk_fall = r_sclk_d & ~w_sclk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_cs_fall) w_state_next = SHIFT;
      SHIFT:   if (w_cs_rise) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // A word is loaded at select, and after each completed word on the following sclk fall.
  assign w_load      = ((r_state == IDLE) && w_cs_fall) ||
                       ((r_state == SHIFT) && !w_cs_rise && w_sclk_fall && r_reload);
  assign w_wr        = i_tx_valid & ~r_buf_full;
  assign w_next_word = r_buf_full ? r_buf : IDLE_WORD;
  assign w_rx_next   = {r_rx_shift[WIDTH-2:0], w_mosi};
  assign w_bit_idx   = CW'(WIDTH - 1) - r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf      <= '0;
      r_buf_full <= 1'b0;
    end else if (w_wr) begin
      r_buf      <= i_tx_data;
      r_buf_full <= 1'b1;
    end else if (w_load) begin
      r_buf_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_rx_shift <= '0;
      r_tx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;
      r_miso     <= 1'b0;
      r_miso_oe  <= 1'b0;
      r_reload   <= 1'b0;
      r_und_pend <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;
      if ((r_state == IDLE) && w_cs_fall) begin
        r_tx_shift <= w_next_word;
        r_miso     <= w_next_word[WIDTH-1];
        r_miso_oe  <= 1'b1;
        r_underrun <= ~r_buf_full;
        r_reload   <= 1'b0;
        r_und_pend <= 1'b0;
        r_cnt      <= '0;
        if (w_sclk_rise) begin
          r_rx_shift <= w_rx_next;
          r_cnt      <= CW'(1);
        end
      end else if (r_state == SHIFT) begin
        if (w_cs_rise) begin
          r_miso_oe  <= 1'b0;
          r_miso     <= 1'b0;
          r_cnt      <= '0;
          r_reload   <= 1'b0;
          r_und_pend <= 1'b0;
        end else if (w_sclk_rise) begin
          r_rx_shift <= w_rx_next;
          // An empty-buffer reload only counts as underrun once the master clocks that word.
          if (r_und_pend) begin
            r_underrun <= 1'b1;
            r_und_pend <= 1'b0;
          end
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_rx_data  <= w_rx_next;
            r_rx_valid <= 1'b1;
            r_cnt      <= '0;
            r_reload   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end else if (w_sclk_fall) begin
          if (r_reload) begin
            r_tx_shift <= w_next_word;
            r_miso     <= w_next_word[WIDTH-1];
            r_reload   <= 1'b0;
            r_und_pend <= ~r_buf_full;
          end else begin
            r_miso <= r_tx_shift[w_bit_idx];
          end
        end
      end
    end
  end

  assign o_miso     = r_miso;
  assign o_miso_oe  = r_miso_oe;
  assign o_tx_ready = ~r_buf_full;
  assign o_rx_data  = r_rx_data;
  assign o_rx_valid = r_rx_valid;
  assign o_underrun = r_underrun;
  assign o_state    = r_state;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a behavioural SPI mode-0 master plus tx-buffer feeder,
// with received words and underrun pulses collected by a monitor.
module tb_spi_slave;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_cs_n, i_sclk, i_mosi, i_tx_valid;
  logic [W-1:0] i_tx_data;
  logic         o_miso, o_miso_oe, o_tx_ready, o_rx_valid, o_underrun, o_state;
  logic [W-1:0] o_rx_data;

  int errors = 0;
  int checks = 0;
  int und_cnt = 0;
  logic [W-1:0] mosi_q[$];
  logic [W-1:0] miso_q[$];
  logic [W-1:0] rx_q[$];
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  spi_slave #(.WIDTH(W), .IDLE_WORD(8'h00), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .i_cs_n(i_cs_n), .i_sclk(i_sclk), .i_mosi(i_mosi),
    .o_miso(o_miso), .o_miso_oe(o_miso_oe), .i_tx_data(i_tx_data),
    .i_tx_valid(i_tx_valid), .o_tx_ready(o_tx_ready), .o_rx_data(o_rx_data),
    .o_rx_valid(o_rx_valid), .o_underrun(o_underrun), .o_state(o_state)
  );

  always @(negedge clk) begin
    if (o_rx_valid) rx_q.push_back(o_rx_data);
    if (o_underrun) und_cnt++;
  end

  task automatic clear_logs();
    rx_q.delete(); miso_q.delete(); mosi_q.delete(); exp_q.delete();
    und_cnt = 0;
  endtask

  task automatic push_tx(input logic [W-1:0] d);
    int t = 0;
    while (!o_tx_ready && t < 1000) begin @(negedge clk); t++; end
    if (!o_tx_ready) begin
      checks++; errors++;
      $display("FAIL push_timeout: tx_ready=%b want 1", o_tx_ready);
    end
    i_tx_data = d; i_tx_valid = 1'b1;
    @(negedge clk);
    i_tx_valid = 1'b0;
  endtask

  // miso is sampled late in the high phase to allow for the responder's synchroniser delay.
  task automatic spi_bits(input logic [W-1:0] mw, input int nb, input int hp,
                          output logic [W-1:0] sw);
    sw = '0;
    for (int k = 0; k < nb; k++) begin
      i_mosi = mw[W-1-k];
      repeat (hp) @(negedge clk);
      i_sclk = 1'b1;
      repeat (hp - 1) @(negedge clk);
      #4 sw[W-1-k] = o_miso;
      @(negedge clk);
      i_sclk = 1'b0;
    end
  endtask

  task automatic spi_xfer(input int hp);
    logic [W-1:0] sw;
    i_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    foreach (mosi_q[i]) begin
      spi_bits(mosi_q[i], W, hp, sw);
      miso_q.push_back(sw);
    end
    repeat (4) @(negedge clk);
    i_cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic check_words(input string name, input logic [W-1:0] txw[$]);
    checks++;
    if (rx_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL %s_rx_count: got %0d want %0d", name, rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL %s_rx[%0d]: got %h want %h", name, i, rx_q[i], exp_q[i]);
      end
    end
    for (int i = 0; i < txw.size() && i < miso_q.size(); i++) begin
      checks++;
      if (miso_q[i] !== txw[i]) begin
        errors++; $display("FAIL %s_miso[%0d]: got %h want %h", name, i, miso_q[i], txw[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; i_cs_n = 1'b1; i_sclk = 1'b0; i_mosi = 1'b0;
    i_tx_data = '0; i_tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (o_miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b want 0", o_miso); end
    checks++; if (o_miso_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b want 0", o_miso_oe); end
    checks++; if (o_tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b want 1", o_tx_ready); end
    checks++; if (o_rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h want 00", o_rx_data); end
    checks++; if (o_rx_valid !== 1'b0 || o_underrun !== 1'b0) begin
      errors++; $display("FAIL reset_pulses: got %b%b want 00", o_rx_valid, o_underrun);
    end
    checks++; if (o_state !== 1'b0) begin errors++; $display("FAIL reset_state: got %b want 0", o_state); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single();
    clear_logs();
    push_tx(8'hA5);
    checks++; if (o_tx_ready !== 1'b0) begin errors++; $display("FAIL single_ready_full: got %b want 0", o_tx_ready); end
    mosi_q.push_back(8'h3C); exp_q.push_back(8'h3C);
    spi_xfer(3);
    check_words("single", '{8'hA5});
    checks++; if (und_cnt !== 0) begin errors++; $display("FAIL single_underrun: got %0d want 0", und_cnt); end
    checks++; if (o_tx_ready !== 1'b1) begin errors++; $display("FAIL single_ready_empty: got %b want 1", o_tx_ready); end
    checks++; if (o_miso_oe !== 1'b0) begin errors++; $display("FAIL single_oe_off: got %b want 0", o_miso_oe); end
  endtask

  task automatic test_underrun();
    clear_logs();
    mosi_q.push_back(8'hFF); exp_q.push_back(8'hFF);
    spi_xfer(3);
    check_words("underrun", '{8'h00});
    checks++; if (und_cnt !== 1) begin errors++; $display("FAIL underrun_count: got %0d want 1", und_cnt); end
  endtask

  task automatic test_back_to_back();
    clear_logs();
    push_tx(8'h11);
    mosi_q = '{8'hC1, 8'hC2, 8'hC3};
    exp_q  = '{8'hC1, 8'hC2, 8'hC3};
    fork
      spi_xfer(3);
      begin push_tx(8'h22); push_tx(8'h33); end
    join
    check_words("b2b", '{8'h11, 8'h22, 8'h33});
    checks++; if (und_cnt !== 0) begin errors++; $display("FAIL b2b_underrun: got %0d want 0", und_cnt); end
  endtask

  task automatic test_abort();
    logic [W-1:0] sw;
    clear_logs();
    push_tx(8'hC3);
    i_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    spi_bits(8'hB4, 5, 2, sw);
    checks++; if (o_miso_oe !== 1'b1) begin errors++; $display("FAIL abort_oe_on: got %b want 1", o_miso_oe); end
    checks++; if (sw[7:3] !== 5'b11000) begin errors++; $display("FAIL abort_miso_bits: got %b want 11000", sw[7:3]); end
    i_cs_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (o_miso_oe !== 1'b0 || o_miso !== 1'b0) begin
      errors++; $display("FAIL abort_oe_off: got oe=%b miso=%b want 0 0", o_miso_oe, o_miso);
    end
    repeat (6) @(negedge clk);
    checks++; if (rx_q.size() !== 0) begin errors++; $display("FAIL abort_rx_valid: got %0d pulses want 0", rx_q.size()); end
    checks++; if (o_rx_data !== 8'hC3) begin errors++; $display("FAIL abort_rx_hold: got %h want c3", o_rx_data); end
    clear_logs();
    push_tx(8'h69);
    mosi_q.push_back(8'h7E); exp_q.push_back(8'h7E);
    spi_xfer(2);
    check_words("abort_next", '{8'h69});
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] sw;
    clear_logs();
    push_tx(8'hA5);
    i_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    spi_bits(8'hF0, 3, 2, sw);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (o_miso !== 1'b0 || o_miso_oe !== 1'b0) begin
      errors++; $display("FAIL rstmid_pins: got miso=%b oe=%b want 0 0", o_miso, o_miso_oe);
    end
    checks++; if (o_tx_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", o_tx_ready); end
    checks++; if (o_rx_data !== 8'h00 || o_state !== 1'b0) begin
      errors++; $display("FAIL rstmid_regs: got rx=%h state=%b want 00 0", o_rx_data, o_state);
    end
    i_cs_n = 1'b1; i_sclk = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (rx_q.size() !== 0) begin errors++; $display("FAIL rstmid_rx_valid: got %0d pulses want 0", rx_q.size()); end
    clear_logs();
    push_tx(8'h5A);
    mosi_q.push_back(8'h96); exp_q.push_back(8'h96);
    spi_xfer(2);
    check_words("rstmid_next", '{8'h5A});
    checks++; if (und_cnt !== 0) begin errors++; $display("FAIL rstmid_underrun: got %0d want 0", und_cnt); end
  endtask

  task automatic test_random();
    logic [W-1:0] txw[$];
    clear_logs();
    for (int i = 0; i < 64; i++) begin
      mosi_q.push_back(W'($urandom_range(0, 255)));
      exp_q.push_back(mosi_q[i]);
      txw.push_back(W'($urandom_range(0, 255)));
    end
    push_tx(txw[0]);
    fork
      spi_xfer(2);
      for (int i = 1; i < 64; i++) push_tx(txw[i]);
    join
    check_words("random", txw);
    checks++; if (und_cnt !== 0) begin errors++; $display("FAIL random_underrun: got %0d want 0", und_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_underrun();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
